hamming_tx_serializer: RTL and testbench

HAMMING_TX_SERIALIZER -- requirements
Module: hamming_tx_serializer

---
 rtl/hamming_tx_serializer.sv | 113 +++++++++++
 tb/tb_hamming_tx_serializer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_tx_serializer.sv
// Hamming(15,11) even-parity encoder feeding a bit serializer paced by a shared shift strobe.
// A new word can be taken on the last bit of the current frame, giving gap-free back-to-back frames.
//
// state  | meaning
// S_IDLE | no frame in flight, sl_out parked at IDLE_BIT, ready for a word
// S_SEND | codeword in flight, one bit per shift strobe
module hamming_tx_serializer #(
    parameter bit IDLE_BIT  = 1'b0,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [10:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic        shift,
    output logic        sl_out,
    output logic        frame_start,
    output logic        busy,
    output logic [14:0] code_out,
    output logic [3:0]  bit_cnt
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [14:0] sr_q, sr_d;
    logic [14:0] code_q, code_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [14:0] enc_w;
    logic        last_bit_w;
    logic        head_w;

    // Index c[p] is codeword position p; position p lands on code bit p-1.
    function automatic logic [14:0] hamming_encode(input logic [10:0] d);
        logic [15:1] c;
        c     = '0;
        c[3]  = d[0];
        c[5]  = d[1];
        c[6]  = d[2];
        c[7]  = d[3];
        c[9]  = d[4];
        c[10] = d[5];
        c[11] = d[6];
        c[12] = d[7];
        c[13] = d[8];
        c[14] = d[9];
        c[15] = d[10];
        c[1]  = c[3] ^ c[5] ^ c[7]  ^ c[9]  ^ c[11] ^ c[13] ^ c[15];
        c[2]  = c[3] ^ c[6] ^ c[7]  ^ c[10] ^ c[11] ^ c[14] ^ c[15];
        c[4]  = c[5] ^ c[6] ^ c[7]  ^ c[12] ^ c[13] ^ c[14] ^ c[15];
        c[8]  = c[9] ^ c[10] ^ c[11] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
        return c;
    endfunction

    assign enc_w       = hamming_encode(data_in);
    assign busy        = (state_q == S_SEND);
    assign last_bit_w  = busy && shift && (cnt_q == 4'd14);
    assign data_ready  = !busy || last_bit_w;
    assign head_w      = MSB_FIRST ? sr_q[14] : sr_q[0];
    assign sl_out      = busy ? head_w : IDLE_BIT;
    assign frame_start = busy && (cnt_q == 4'd0);
    assign code_out    = code_q;
    assign bit_cnt     = cnt_q;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (data_valid) begin
                    state_d = S_SEND;
                    sr_d    = enc_w;
                    code_d  = enc_w;
                    cnt_d   = 4'd0;
                end
            end
            S_SEND: begin
                if (last_bit_w) begin
                    if (data_valid) begin
                        sr_d   = enc_w;
                        code_d = enc_w;
                    end else begin
                        state_d = S_IDLE;
                    end
                    cnt_d = 4'd0;
                end else if (shift) begin
                    sr_d  = MSB_FIRST ? {sr_q[13:0], 1'b0} : {1'b0, sr_q[14:1]};
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            code_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Bench for hamming_tx_serializer: LSB-first and MSB-first instances share one stimulus;
// a negedge monitor rebuilds each frame and checks it against a scoreboard of expected codewords.
module tb_hamming_tx_serializer;

    typedef struct {
        logic [10:0] d;
        logic [14:0] code;
    } vec_t;

    logic        clk;
    logic        RST;
    logic [10:0] data_in;
    logic        data_valid;
    logic        shift;
    logic        data_ready, sl_out, frame_start, busy;
    logic [14:0] code_out;
    logic [3:0]  bit_cnt;
    logic        data_ready_m, sl_out_m, frame_start_m, busy_m;
    logic [14:0] code_out_m;
    logic [3:0]  bit_cnt_m;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rand_mode = 1'b0;
    bit   track_busy = 1'b0;
    int   idx = 0;
    logic [14:0] rx_l, rx_m;
    vec_t sb[$];
    vec_t vecs[7];

    hamming_tx_serializer #(.IDLE_BIT(1'b0), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .RST(RST), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .shift(shift), .sl_out(sl_out),
        .frame_start(frame_start), .busy(busy), .code_out(code_out), .bit_cnt(bit_cnt)
    );

    hamming_tx_serializer #(.IDLE_BIT(1'b1), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .RST(RST), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready_m), .shift(shift), .sl_out(sl_out_m),
        .frame_start(frame_start_m), .busy(busy_m), .code_out(code_out_m), .bit_cnt(bit_cnt_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Generic formulation: non-power-of-two positions take data in order, then each parity covers its set.
    function automatic logic [14:0] model_enc(input logic [10:0] d);
        logic [15:1] c;
        logic        par;
        int          j;
        c = '0;
        j = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            par = 1'b0;
            for (int p = 1; p <= 15; p++)
                if (((p >> k) & 1) == 1 && p != (1 << k)) par ^= c[p];
            c[1 << k] = par;
        end
        return c;
    endfunction

    function automatic logic [3:0] model_syndrome(input logic [14:0] cw);
        logic [3:0] s;
        s = 4'd0;
        for (int p = 1; p <= 15; p++)
            if (cw[p-1]) s ^= 4'(p);
        return s;
    endfunction

    function automatic logic [10:0] model_extract(input logic [14:0] cw);
        logic [10:0] d;
        int          j;
        d = '0;
        j = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[j] = cw[p-1];
                j++;
            end
        end
        return d;
    endfunction

    always @(negedge clk) begin
        vec_t e;
        if (!RST) begin
            idx = 0;
            sb.delete();
        end else begin
            if (track_busy && !busy) check("busy_continuous", 32'(busy), 32'd1);
            if (busy && shift) begin
                check("frame_start", 32'(frame_start), 32'(idx == 0));
                check("frame_start_m", 32'(frame_start_m), 32'(idx == 0));
                check("bit_cnt", 32'(bit_cnt), 32'(idx));
                check("bit_cnt_m", 32'(bit_cnt_m), 32'(idx));
                rx_l[idx]      = sl_out;
                rx_m[14 - idx] = sl_out_m;
                if (idx == 14) begin
                    idx = 0;
                    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("stream_lsb", 32'(rx_l), 32'(e.code));
                        check("stream_msb", 32'(rx_m), 32'(e.code));
                        check("code_out", 32'(code_out), 32'(e.code));
                        check("code_out_m", 32'(code_out_m), 32'(e.code));
                        check("rx_syndrome", 32'(model_syndrome(rx_l)), 32'd0);
                        check("rx_decoded", 32'(model_extract(rx_l)), 32'(e.d));
                    end
                end else begin
                    idx++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        shift = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic send(input logic [10:0] d, input logic [14:0] code);
        bit ok;
        vec_t e;
        ok = 1'b0;
        data_in    = d;
        data_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (data_ready) begin
                e.d = d;
                e.code = code;
                sb.push_back(e);
                ok = 1'b1;
            end
            step();
        end
        data_valid = 1'b0;
        data_in    = 11'($urandom);
        check("send_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) done = 1'b1;
            else step();
        end
        check("wait_idle", 32'(done), 32'd1);
        step();
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, "_ready"}, 32'(data_ready), 32'd1);
        check({tag, "_ready_m"}, 32'(data_ready_m), 32'd1);
        check({tag, "_busy"}, 32'(busy | busy_m), 32'd0);
        check({tag, "_fs"}, 32'(frame_start | frame_start_m), 32'd0);
        check({tag, "_sl"}, 32'(sl_out), 32'd0);
        check({tag, "_sl_m"}, 32'(sl_out_m), 32'd1);
        check({tag, "_cnt"}, 32'({bit_cnt, bit_cnt_m}), 32'd0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{11'h000, 15'h0000};
        vecs[1] = '{11'h001, 15'h0007};
        vecs[2] = '{11'h002, 15'h0019};
        vecs[3] = '{11'h004, 15'h002A};
        vecs[4] = '{11'h008, 15'h004B};
        vecs[5] = '{11'h400, 15'h408B};
        vecs[6] = '{11'h7FF, 15'h7FFF};

        RST        = 1'b0;
        data_valid = 1'b1;
        data_in    = 11'h7FF;
        shift      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        RST        = 1'b1;
        data_valid = 1'b0;
        @(negedge clk);
        check("rst_code", 32'(code_out), 32'd0);
        check("rst_code_m", 32'(code_out_m), 32'd0);
        step();
        check_idle("rst");

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].d, vecs[i].code);
            wait_idle();
            check_idle("post_vec");
        end

        // Zero-gap back-to-back frames: busy must not drop and bit 15 is a new frame start.
        send(11'h0A5, model_enc(11'h0A5));
        track_busy = 1'b1;
        send(11'h35A, model_enc(11'h35A));
        @(negedge clk);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_fs", 32'(frame_start), 32'd1);
        track_busy = 1'b0;
        step();
        wait_idle();

        // Stalled shifting: bits must be held while shift is low.
        rand_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [10:0] d;
            d = 11'($urandom);
            send(d, model_enc(d));
        end
        wait_idle();
        rand_mode = 1'b0;
        check_idle("post_rand");

        // Reset mid-frame at bit 7 aborts the frame.
        send(11'h5C3, model_enc(11'h5C3));
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 40 && !hit; i++) begin
                @(negedge clk);
                if (bit_cnt == 4'd6) hit = 1'b1;
                step();
            end
            check("reach_bit6", 32'(hit), 32'd1);
        end
        RST        = 1'b0;
        data_valid = 1'b1;
        @(negedge clk);
        check("pre_rst_cnt", 32'(bit_cnt), 32'd7);
        @(posedge clk);
        #1;
        RST        = 1'b1;
        data_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cnt", 32'(bit_cnt), 32'd0);
        check("abort_sl", 32'(sl_out), 32'd0);
        check("abort_sl_m", 32'(sl_out_m), 32'd1);
        check("abort_code", 32'(code_out), 32'd0);
        step();
        send(11'h1E7, model_enc(11'h1E7));
        wait_idle();
        check_idle("post_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
